plot_buffer: RTL and testbench
==============================

PLOT_BUFFER -- requirements
Module: plot_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of two, >=2).
REQ-002 Parameter SCREEN_W, default 160, visible width in pixels.
REQ-003 Parameter SCREEN_H, default 120, visible height in pixels.
REQ-004 The block SHALL have these ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush of FIFO, flags and counters.
- in_valid  in  1  drawing engine offers a pixel.
- in_ready  out  1  block accepts the offered pixel this cycle.
- in_x  in  8  pixel X.
- in_y  in  7  pixel Y.
- in_colour  in  3  pixel colour.
- in_last  in  1  marks final pixel of a figure.
- out_plot  out  1  head pixel valid; wired to VGA_PLOT.
- out_ready  in  1  VGA side accepts the head pixel.
- out_x  out  8  head X; wired to VGA_X.
- out_y  out  7  head Y; wired to VGA_Y.
- out_colour  out  3  head colour; wired to VGA_COLOUR.
- done  out  1  one-cycle pulse: figure fully emitted.
- plotted_cnt  out  15  pixels emitted since reset/clr.
- clipped_cnt  out  15  pixels dropped by clipping since reset/clr.

Function
REQ-005 Accept = in_valid && in_ready; in_ready SHALL equal (occupancy != DEPTH) && !clr.
REQ-006 An accepted pixel with in_x >= SCREEN_W or in_y >= SCREEN_H SHALL be clipped: not stored, clipped_cnt +1.
REQ-007 An accepted in-bounds pixel SHALL be written at the FIFO tail; order SHALL be preserved.
REQ-008 FIFO SHALL be show-ahead: out_plot = occupancy != 0; out_x/out_y/out_colour reflect head entry, driven from registers.
REQ-009 Latency: a pixel pushed into an empty FIFO at edge N SHALL appear with out_plot=1 after edge N (one cycle).
REQ-010 Pop = out_plot && out_ready; on pop, head advances and plotted_cnt +1.
REQ-011 Simultaneous push and pop SHALL leave occupancy unchanged; with occupancy == DEPTH no push occurs (in_ready=0) but pop proceeds.
REQ-012 Pointers SHALL wrap modulo DEPTH; occupancy range 0..DEPTH; no overflow or underflow under any stimulus.
REQ-013 When out_plot=0, out_x/out_y/out_colour SHALL hold last values (don't-care for checking).
REQ-014 Accepting any beat with in_last=1 (clipped or not) SHALL set last_seen.
REQ-015 done SHALL pulse for exactly one cycle on the first edge where last_seen=1, occupancy=0 and no push occurs; last_seen clears on the same edge.
REQ-016 A last beat that is clipped into an empty FIFO SHALL produce done one cycle after acceptance.
REQ-017 Counters SHALL saturate at 32767 and never wrap.
REQ-018 clr=1 SHALL, on the next edge, empty the FIFO, clear last_seen, zero both counters; done=0 and in_ready=0 while clr=1; clr overrides same-cycle push/pop.
REQ-019 Control FSM states: IDLE (empty, last_seen=0), FILL (occupancy>0), DRAIN (last_seen=1, occupancy>0), DONE (one-cycle, drives done) -> IDLE.

Reset
REQ-020 rst=1 SHALL asynchronously force: occupancy 0, pointers 0, out_plot 0, in_ready 0 (while rst asserted), done 0, last_seen 0, counters 0, out_x/out_y/out_colour 0, FSM IDLE.
REQ-021 rst asserted mid-figure SHALL discard all buffered pixels; no done follows.
REQ-022 First accept possible on the first edge after rst deasserts.

Structure
REQ-023 Package plot_pkg SHALL hold SCREEN_W, SCREEN_H, pixel_t struct (x 8, y 7, colour 3) and the FSM state enum.
REQ-024 Storage SHALL be a sub-module plot_fifo (show-ahead, DEPTH-parameterised, clr input); clipping, counters and FSM live in plot_buffer.

Verification
REQ-025 Push (10,20,3'b100),(11,20,3'b100) with out_ready=1 -> same two pixels emitted in order, first one cycle after push; plotted_cnt=2.
REQ-026 out_ready=0, push 9 pixels -> 8 accepted, in_ready=0 on 9th; raise out_ready -> 8 emitted, then 9th accepted.
REQ-027 Push (160,0),(0,120),(159,119),(255,127) -> only (159,119) emitted; clipped_cnt=3, plotted_cnt=1.
REQ-028 Stream 30 pixels, last flagged, out_ready toggling 1/0 -> done exactly once, cycle after 30th pop; clipped last (200,5) into empty FIFO -> done next cycle.
REQ-029 rst pulse with 5 pixels buffered -> out_plot=0 immediately, counters 0, no done; clr likewise on next edge.
REQ-030 Drive 32800 in-bounds pixels with out_ready=1 -> plotted_cnt holds 32767.

Source files
------------

// File: rtl/plot_pkg.sv
// Shared types for the pixel plot buffer: screen geometry, pixel record, control states.
package plot_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned CNT_W    = 15;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_DONE
  } plot_state_e;

  // Counters stick at full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Show-ahead pixel FIFO, head held in a register; one cycle from push into empty to head valid.
// Push ignored when full, pop ignored when empty; clr empties on the next edge.
module plot_fifo
  import plot_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  pixel_t                   din,
  input  logic                     pop,
  output pixel_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);

  pixel_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_nxt;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Incoming pixel becomes head directly when nothing else will be left ahead of it.
      if (do_push && (empty || (do_pop && count == ONE_CNT))) begin
        head <= din;
      end else if (do_pop && count > ONE_CNT) begin
        head <= mem[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/plot_buffer.sv
// Clips, buffers and streams drawing-engine pixels to the VGA plotter; head valid one cycle after push.
// in_ready drops when the FIFO is full or clr is high; done pulses once a flagged figure has fully drained.
module plot_buffer
  import plot_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned SCREEN_W = plot_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = plot_pkg::SCREEN_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [2:0]  in_colour,
  input  logic        in_last,
  output logic        out_plot,
  input  logic        out_ready,
  output logic [7:0]  out_x,
  output logic [6:0]  out_y,
  output logic [2:0]  out_colour,
  output logic        done,
  output logic [14:0] plotted_cnt,
  output logic [14:0] clipped_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  pixel_t      in_pix;
  pixel_t      head;
  logic [CW-1:0] occ;
  logic [CW-1:0] occ_nxt;
  logic        full;
  logic        empty;
  logic        clip;
  logic        accept;
  logic        push;
  logic        pop;
  logic        fire;
  logic        last_seen;
  logic        last_nxt;
  plot_state_e state;
  plot_state_e state_nxt;

  assign in_pix   = '{x: in_x, y: in_y, colour: in_colour};
  assign in_ready = !full && !clr && !rst;
  assign accept   = in_valid && in_ready;
  assign clip     = (32'(in_x) >= SCREEN_W) || (32'(in_y) >= SCREEN_H);
  assign push     = accept && !clip;
  assign out_plot = !empty;
  assign pop      = out_plot && out_ready && !clr;

  plot_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .din   (in_pix),
    .pop   (pop),
    .head  (head),
    .count (occ),
    .full  (full),
    .empty (empty)
  );

  assign out_x      = head.x;
  assign out_y      = head.y;
  assign out_colour = head.colour;

  // A figure is finished once its last beat has been seen and nothing is left or arriving.
  assign fire = last_seen && empty && !push;
  assign done = (state == ST_DONE) && !clr;

  always_comb begin
    occ_nxt = occ;
    if (push && !pop) begin
      occ_nxt = occ + 1'b1;
    end else if (pop && !push) begin
      occ_nxt = occ - 1'b1;
    end
  end

  always_comb begin
    last_nxt = last_seen;
    if (accept && in_last) begin
      last_nxt = 1'b1;
    end else if (fire) begin
      last_nxt = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_FILL, ST_DRAIN: begin
        if (fire) begin
          state_nxt = ST_DONE;
        end else if (occ_nxt != '0) begin
          state_nxt = last_nxt ? ST_DRAIN : ST_FILL;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (fire) begin
          state_nxt = ST_DONE;
        end else if (occ_nxt != '0) begin
          state_nxt = last_nxt ? ST_DRAIN : ST_FILL;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clr) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_seen   <= 1'b0;
      plotted_cnt <= '0;
      clipped_cnt <= '0;
    end else if (clr) begin
      state       <= ST_IDLE;
      last_seen   <= 1'b0;
      plotted_cnt <= '0;
      clipped_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last_seen <= last_nxt;
      if (pop) begin
        plotted_cnt <= sat_inc(plotted_cnt);
      end
      if (accept && clip) begin
        clipped_cnt <= sat_inc(clipped_cnt);
      end
    end
  end

endmodule

// File: tb/tb_plot_buffer.sv
// Randomised scoreboard bench for plot_buffer with an independent cycle-level reference model.
module tb_plot_buffer;

  localparam int DEPTH = 8;
  localparam int W     = 160;
  localparam int H     = 120;
  localparam int SAT   = 32767;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_colour;
  logic        in_last;
  logic        out_plot;
  logic        out_ready;
  logic [7:0]  out_x;
  logic [6:0]  out_y;
  logic [2:0]  out_colour;
  logic        done;
  logic [14:0] plotted_cnt;
  logic [14:0] clipped_cnt;

  plot_buffer #(
    .DEPTH    (DEPTH),
    .SCREEN_W (W),
    .SCREEN_H (H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_colour   (in_colour),
    .in_last     (in_last),
    .out_plot    (out_plot),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_colour  (out_colour),
    .done        (done),
    .plotted_cnt (plotted_cnt),
    .clipped_cnt (clipped_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
  } px_t;

  px_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  mocc, mplot, mclip;
  bit  mlast, mdone;
  int  done_seen = 0;
  int  mode = 0;  // out_ready pattern: 0 low, 1 high, 2 toggle, 3 random

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: predicts handshake, done and counters from the rules, one cycle ahead.
  initial begin
    bit acc, clipb, pushb, popb, fire;
    forever begin
      @(negedge clk);
      if (rst) begin
        mocc = 0; mplot = 0; mclip = 0; mlast = 0; mdone = 0;
        exp_q.delete();
      end else begin
        check("in_ready", int'(in_ready), int'(mocc != DEPTH && !clr));
        check("out_plot", int'(out_plot), int'(mocc != 0));
        check("done", int'(done), int'(mdone && !clr));
        check("plotted_cnt", int'(plotted_cnt), mplot);
        check("clipped_cnt", int'(clipped_cnt), mclip);
        acc   = in_valid && (mocc != DEPTH) && !clr;
        clipb = (int'(in_x) >= W) || (int'(in_y) >= H);
        pushb = acc && !clipb;
        popb  = (mocc != 0) && out_ready;
        if (clr) begin
          mocc = 0; mplot = 0; mclip = 0; mlast = 0; mdone = 0;
          exp_q.delete();
        end else begin
          fire  = mlast && (mocc == 0) && !pushb;
          mdone = fire;
          if (acc && in_last) mlast = 1;
          else if (fire) mlast = 0;
          mocc = mocc + int'(pushb) - int'(popb);
          if (popb && mplot < SAT) mplot++;
          if (acc && clipb && mclip < SAT) mclip++;
          if (pushb) exp_q.push_back('{int'(in_x), int'(in_y), int'(in_colour)});
        end
      end
    end
  end

  // Monitor: every pixel the VGA side takes must be the next expected one.
  initial begin
    px_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) done_seen++;
      if (!rst && !clr && out_plot && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pixel_unexpected: got (%0d,%0d,%0d) expected none", out_x, out_y, out_colour);
        end else begin
          e = exp_q.pop_front();
          check("pixel_x", int'(out_x), e.x);
          check("pixel_y", int'(out_y), e.y);
          check("pixel_colour", int'(out_colour), e.c);
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        2:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int x, input int y, input int c, input bit last);
    int n;
    bit acc;
    n = 0;
    acc = 0;
    in_valid = 1'b1;
    in_x = x[7:0];
    in_y = y[6:0];
    in_colour = c[2:0];
    in_last = last;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: pixel (%0d,%0d) not accepted within 300 cycles", x, y);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    check("rst_out_plot", int'(out_plot), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_plotted", int'(plotted_cnt), 0);
    check("rst_clipped", int'(clipped_cnt), 0);
    check("rst_out_xyc", int'({out_x, out_y, out_colour}), 0);
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    clr = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0; in_last = 1'b0;
    pulse_rst();

    // Two pixels straight through.
    mode = 1;
    idle(1);
    send(10, 20, 4, 0);
    send(11, 20, 4, 0);
    idle(4);
    check("two_px_plotted", int'(plotted_cnt), 2);

    // Fill to capacity with the VGA side stalled, then release.
    pulse_clr();
    mode = 0;
    idle(2);
    for (int i = 0; i < 8; i++) send(20 + i, 30, i, 0);
    idle(2);
    check("full_in_ready", int'(in_ready), 0);
    check("full_out_plot", int'(out_plot), 1);
    mode = 1;
    send(40, 40, 7, 0);
    idle(12);
    check("full_plotted", int'(plotted_cnt), 9);

    // Clipping boundaries.
    pulse_clr();
    send(160, 0, 1, 0);
    send(0, 120, 2, 0);
    send(159, 119, 3, 0);
    send(255, 127, 5, 0);
    idle(4);
    check("clip_clipped", int'(clipped_cnt), 3);
    check("clip_plotted", int'(plotted_cnt), 1);

    // 30-pixel figure with toggling out_ready, then a clipped last beat.
    pulse_clr();
    mode = 2;
    done_seen = 0;
    for (int i = 0; i < 30; i++) send($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7), i == 29);
    idle(20);
    check("fig_done_count", done_seen, 1);
    check("fig_plotted", int'(plotted_cnt), 30);
    done_seen = 0;
    send(200, 5, 6, 1);
    idle(5);
    check("clipped_last_done_count", done_seen, 1);

    // Reset and clear with a figure buffered: nothing drains, no done.
    mode = 0;
    for (int i = 0; i < 5; i++) send(i, i, i, i == 4);
    done_seen = 0;
    pulse_rst();
    mode = 1;
    idle(10);
    check("rst_mid_done_count", done_seen, 0);
    mode = 0;
    for (int i = 0; i < 5; i++) send(50 + i, 60, i, i == 4);
    pulse_clr();
    mode = 1;
    idle(10);
    check("clr_mid_done_count", done_seen, 0);
    check("clr_mid_out_plot", int'(out_plot), 0);

    // Random traffic with mixed clipping, last flags and occasional clears.
    mode = 3;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) send($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 15) == 0);
      else send($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7), $urandom_range(0, 15) == 0);
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 99) == 0) pulse_clr();
    end
    mode = 1;
    idle(20);

    // Counter saturation.
    pulse_clr();
    for (int i = 0; i < 32800; i++) send(i % W, i % H, i % 8, 0);
    idle(6);
    check("sat_plotted", int'(plotted_cnt), SAT);
    check("sat_clipped", int'(clipped_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
